// File: rtl/alu_pkg.sv
// Shared definitions for the 2-bit ALU, its operand sequencer and the bench model.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        EXEC    = 2'b11
    } seq_state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a pre-synchronized button level.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic btn_q;
    logic btn_d;

    always_comb begin
        btn_d = btn;
    end

    // Resetting to 1 means a button already held at reset release is not a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode over three button presses, drives the ALU, captures its result.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_c,
    output logic [WIDTH-1:0] res_y,
    output logic             res_c,
    output logic             res_zero,
    output logic             done,
    output logic [1:0]       step
);

    logic press;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .press (press)
    );

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    op_t              alu_s_q, alu_s_d;
    logic [WIDTH-1:0] res_y_q, res_y_d;
    logic             res_c_q, res_c_d;
    logic             res_zero_q, res_zero_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_s_d    = alu_s_q;
        res_y_d    = res_y_q;
        res_c_d    = res_c_q;
        res_zero_d = res_zero_q;
        done_d     = 1'b0;

        case (state_q)
            LOAD_A: begin
                if (press && !abort) begin
                    alu_a_d = sw;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press && !abort) begin
                    alu_b_d = sw;
                    state_d = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (press && !abort) begin
                    alu_s_d = op_t'(sw[1:0]);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Capture completes even when abort is asserted; only logic ops mask the carry.
                res_y_d    = alu_y;
                res_c_d    = alu_s_q[1] ? alu_c : 1'b0;
                res_zero_d = (alu_y == '0);
                done_d     = 1'b1;
                state_d    = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase

        if (abort) begin
            state_d = LOAD_A;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_s_q    <= OP_AND;
            res_y_q    <= '0;
            res_c_q    <= 1'b0;
            res_zero_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_s_q    <= alu_s_d;
            res_y_q    <= res_y_d;
            res_c_q    <= res_c_d;
            res_zero_q <= res_zero_d;
            done_q     <= done_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_s    = alu_s_q;
    assign res_y    = res_y_q;
    assign res_c    = res_c_q;
    assign res_zero = res_zero_q;
    assign done     = done_q;
    assign step     = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural 2-bit ALU attached.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sw;
    logic             btn;
    logic             abort;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [1:0]       alu_s;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic [WIDTH-1:0] res_y;
    logic             res_c;
    logic             res_zero;
    logic             done;
    logic [1:0]       step;

    int pass_cnt = 0;
    int total    = 0;

    alu_operand_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn      (btn),
        .abort    (abort),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_y    (alu_y),
        .alu_c    (alu_c),
        .res_y    (res_y),
        .res_c    (res_c),
        .res_zero (res_zero),
        .done     (done),
        .step     (step)
    );

    always #5 clk = ~clk;

    // ALU model: carry always comes from the adder except for SUB (borrow),
    // so the sequencer's masking of the carry on logic ops is observable.
    logic [WIDTH:0] sum_w;
    always_comb begin
        sum_w = {1'b0, alu_a} + {1'b0, alu_b};
        case (op_t'(alu_s))
            OP_AND:  alu_y = alu_a & alu_b;
            OP_OR:   alu_y = alu_a | alu_b;
            OP_ADD:  alu_y = sum_w[WIDTH-1:0];
            default: alu_y = alu_a - alu_b;
        endcase
        alu_c = (op_t'(alu_s) == OP_SUB) ? (alu_a < alu_b) : sum_w[WIDTH];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Raise btn for one edge (the load edge), then release it.
    task automatic press(input logic [WIDTH-1:0] v);
        sw  = v;
        btn = 1'b1;
        tick();
        btn = 1'b0;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        press(v);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b1;
        abort = 1'b0;
        sw    = 2'd0;
        tick();
        tick();
        chk("rst_step", step, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_s", alu_s, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst_res_c", res_c, 0);
        chk("rst_zero", res_zero, 1);
        chk("rst_done", done, 0);

        // Button held through reset release: no load.
        rst_n = 1'b1;
        sw    = 2'd2;
        tick();
        tick();
        chk("held_no_load_step", step, 0);
        chk("held_no_load_a", alu_a, 0);
        btn = 1'b0;
        tick();

        // ADD 3+1 -> y=0, c=1, zero=1
        load(2'd3);
        chk("add_step_after_a", step, 1);
        chk("add_a", alu_a, 3);
        load(2'd1);
        chk("add_b", alu_b, 1);
        chk("add_step_after_b", step, 2);
        press(2'd2);
        chk("add_s", alu_s, 2);
        chk("add_step_exec", step, 3);
        chk("add_done_early", done, 0);
        tick();
        chk("add_res_y", res_y, 0);
        chk("add_res_c", res_c, 1);
        chk("add_zero", res_zero, 1);
        chk("add_done", done, 1);
        chk("add_step_back", step, 0);
        tick();
        chk("add_done_once", done, 0);

        // AND 2&3 -> y=2, carry masked
        load(2'd2);
        load(2'd3);
        press(2'd0);
        tick();
        chk("and_res_y", res_y, 2);
        chk("and_res_c", res_c, 0);
        chk("and_zero", res_zero, 0);
        chk("and_done", done, 1);
        tick();

        // OR 1|1 -> y=1, then hold btn for 10 cycles in LOAD_A
        load(2'd1);
        load(2'd1);
        press(2'd1);
        tick();
        chk("or_res_y", res_y, 1);
        chk("or_res_c", res_c, 0);
        tick();
        sw  = 2'd2;
        btn = 1'b1;
        repeat (10) tick();
        chk("hold_step", step, 1);
        chk("hold_a", alu_a, 2);
        chk("hold_b_kept", alu_b, 1);
        chk("hold_res_kept", res_y, 1);
        btn = 1'b0;
        tick();

        // Abort together with press in LOAD_OP
        load(2'd3);
        chk("abort_pre_step", step, 2);
        sw    = 2'd3;
        btn   = 1'b1;
        abort = 1'b1;
        tick();
        chk("abort_step", step, 0);
        chk("abort_s_kept", alu_s, 1);
        chk("abort_done", done, 0);
        abort = 1'b0;
        btn   = 1'b0;
        tick();
        chk("abort_done_later", done, 0);
        chk("abort_step_later", step, 0);
        chk("abort_res_kept", res_y, 1);

        // SUB 2-1 with abort during EXEC: capture still happens
        load(2'd2);
        load(2'd1);
        press(2'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("exec_abort_done", done, 1);
        chk("exec_abort_res_y", res_y, 1);
        chk("exec_abort_res_c", res_c, 0);
        chk("exec_abort_step", step, 0);
        tick();

        // Reset in LOAD_B with alu_a=3
        load(2'd3);
        chk("mid_rst_pre_step", step, 1);
        chk("mid_rst_pre_a", alu_a, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_step", step, 0);
        chk("mid_rst_a", alu_a, 0);
        chk("mid_rst_b", alu_b, 0);
        chk("mid_rst_s", alu_s, 0);
        chk("mid_rst_res_y", res_y, 0);
        chk("mid_rst_res_c", res_c, 0);
        chk("mid_rst_zero", res_zero, 1);
        chk("mid_rst_done", done, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
